// File: rtl/mux7_rr_sched.sv
// Round-robin scheduler for a shared 7:1 bit-select mux.
// Grants one requester at a time, drives the mux select, and bounds each
// grant to HOLD_MAX cycles. Every release is followed by one dead GAP cycle
// so the mux can settle before the next owner is connected.
//
// Handshake contract: gnt/sel/gnt_valid are registered. gnt_valid is high
// exactly while one gnt bit is high, and sel names that bit. A requester keeps
// its grant by holding req high. Dropping req releases the grant at the next
// edge. Reaching the hold limit forces the release and pulses timeout for one
// cycle. sel reads 0 whenever nothing is granted.
module mux7_rr_sched #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] req,
    output logic [6:0] gnt,
    output logic [2:0] sel,
    output logic       gnt_valid,
    output logic       timeout,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       gnt_q, gnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;

    logic [13:0]      req_dbl;
    logic [6:0]       req_rot;
    logic [2:0]       win_off;
    logic [3:0]       win_sum;
    logic [2:0]       win_idx;
    logic             owner_req;

    // Rotate req so bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin
        req_dbl = {req, req};
        req_rot = 7'(req_dbl >> ptr_q);
        win_off = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = 3'(i);
            end
        end
        win_sum = {1'b0, ptr_q} + {1'b0, win_off};
        win_idx = (win_sum >= 4'd7) ? 3'(win_sum - 4'd7) : win_sum[2:0];
    end

    // The current owner is still requesting (gnt is one-hot, so a mask works).
    always_comb begin
        owner_req = |(req & gnt_q);
    end

    // Next-state and output logic for the IDLE -> GRANT -> GAP cycle.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = 7'd0;
                sel_d = 3'd0;
                if (en && (req != 7'd0)) begin
                    gnt_d      = 7'(7'd1 << win_idx);
                    sel_d      = win_idx;
                    hold_cnt_d = '0;
                    ptr_d      = (win_idx == 3'd6) ? 3'd0 : win_idx + 3'd1;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    gnt_d   = 7'd0;
                    sel_d   = 3'd0;
                    state_d = GAP;
                end else if (hold_cnt_q == CNT_W'(HOLD_MAX - 1)) begin
                    gnt_d     = 7'd0;
                    sel_d     = 3'd0;
                    timeout_d = 1'b1;
                    state_d   = GAP;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                gnt_d   = 7'd0;
                sel_d   = 3'd0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = 7'd0;
                sel_d   = 3'd0;
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset wins over everything and drops any live grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 7'd0;
            sel_q      <= 3'd0;
            ptr_q      <= 3'd0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mux7_rr_sched.sv
// Self-checking bench for mux7_rr_sched: directed scenarios plus a random
// phase, all compared against a cycle-level reference model of the grant rules.
module tb_mux7_rr_sched;

    localparam int HOLD_MAX  = 8;
    localparam int CNT_W     = 4;
    localparam int ST_IDLE   = 0;
    localparam int ST_GAP    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [6:0] req = 7'd0;
    logic [6:0] gnt;
    logic [2:0] sel;
    logic       gnt_valid;
    logic       timeout;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];      // {timeout, gnt_valid, sel, gnt} after each edge
    logic [2:0]  exp_gnt_q[$];  // expected winners, in grant order
    logic [2:0]  got_q[$];      // winners observed by the directed driver
    int          to_cnt = 0;
    logic        main_pgv = 1'b0;

    // Clock / reset
    always #5 clk = ~clk;

    mux7_rr_sched #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_order(input string name, input int idx, input int exp);
        if (idx >= got_q.size()) begin
            checks++;
            errors++;
            $display("FAIL %s: grant #%0d missing, required %0d", name, idx, exp);
        end else begin
            check(name, 32'(got_q[idx]), 32'(exp));
        end
    endtask

    // Reference model: owner / cycles-held / dead-edge count / rr pointer.
    int   m_ptr = 0, m_owner = -1, m_held = 0, m_cool = 0, m_w = 0;
    logic m_to = 1'b0, m_found = 1'b0;
    logic [6:0] m_gnt;
    logic [2:0] m_sel;

    initial begin
        forever begin
            @(posedge clk);
            m_to = 1'b0;
            if (rst) begin
                m_ptr = 0; m_owner = -1; m_held = 0; m_cool = 0;
            end else if (m_owner >= 0) begin
                if (!req[m_owner]) begin
                    m_owner = -1; m_cool = 1;
                end else if (m_held >= HOLD_MAX) begin
                    m_owner = -1; m_cool = 1; m_to = 1'b1;
                end else begin
                    m_held++;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else if (en && (req != 7'd0)) begin
                m_found = 1'b0;
                for (int k = 0; k < 7; k++) begin
                    m_w = (m_ptr + k) % 7;
                    if (!m_found && req[m_w]) begin
                        m_found = 1'b1;
                        m_owner = m_w;
                    end
                end
                m_held = 1;
                m_ptr  = (m_owner + 1) % 7;
                exp_gnt_q.push_back(3'(m_owner));
            end
            m_gnt = (m_owner >= 0) ? 7'(1 << m_owner) : 7'd0;
            m_sel = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
            exp_q.push_back({m_to, (m_owner >= 0), m_sel, m_gnt});
        end
    end

    // Scoreboard monitor: pops one expectation per cycle plus one per new grant.
    logic [11:0] mon_e;
    logic        mon_pgv = 1'b0, mon_pto = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("cycle_outputs", {20'd0, timeout, gnt_valid, sel, gnt}, {20'd0, mon_e});
            end
            if (gnt_valid && !mon_pgv) begin
                if (exp_gnt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_order: got grant %0d, required none", sel);
                end else begin
                    check("grant_order", 32'(sel), 32'(exp_gnt_q.pop_front()));
                end
            end
            check("inv_onehot", 32'($countones(gnt) <= 1), 1);
            check("inv_valid", 32'(gnt_valid), 32'(|gnt));
            check("inv_sel", 32'(!gnt_valid || (gnt == 7'(7'd1 << sel))), 1);
            check("inv_to_vs_valid", 32'(timeout && gnt_valid), 0);
            check("inv_to_twice", 32'(timeout && mon_pto), 0);
            mon_pgv = gnt_valid;
            mon_pto = timeout;
        end
    end

    // Driver tasks
    task automatic step();
        @(negedge clk);
        if (gnt_valid && !main_pgv) got_q.push_back(sel);
        if (timeout) to_cnt++;
        main_pgv = gnt_valid;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic run_grants(input int want, input int budget);
        int n0 = got_q.size();
        int c  = 0;
        while ((got_q.size() < n0 + want) && (c < budget)) begin
            step();
            c++;
        end
        check("grant_count", 32'(got_q.size() - n0), 32'(want));
    endtask

    // Every requester asks; the owner drops after drop_after cycles of grant.
    task automatic polite(input int n, input int drop_after);
        int run = 0;
        en = 1'b1;
        repeat (n) begin
            if (gnt_valid) run++; else run = 0;
            req = 7'h7F;
            if (gnt_valid && (run >= drop_after)) req = 7'h7F & ~gnt;
            step();
        end
    endtask

    initial begin
        int hi;

        // Reset state
        rst = 1'b1; en = 1'b0; req = 7'd0;
        repeat (3) step();
        check("reset_gnt", 32'(gnt), 0);
        check("reset_sel", 32'(sel), 0);
        check("reset_valid", 32'(gnt_valid), 0);
        check("reset_timeout", 32'(timeout), 0);
        rst = 1'b0;

        // Single requester held: full-length grant, timeout, gap, regrant
        en = 1'b1; req = 7'b0000100;
        step();
        check("t1_gnt", 32'(gnt), 32'h04);
        check("t1_sel", 32'(sel), 2);
        hi = 1;
        while (gnt_valid && hi < 20) begin
            step();
            if (gnt_valid) hi++;
        end
        check("t1_hold_len", 32'(hi), HOLD_MAX);
        check("t1_timeout", 32'(timeout), 1);
        step();
        check("t1_gap_gnt", 32'(gnt), 0);
        check("t1_gap_timeout", 32'(timeout), 0);
        step();
        check("t1_regrant", 32'(gnt), 32'h04);
        check("t1_regrant_sel", 32'(sel), 2);
        req = 7'd0;
        repeat (3) step();

        // All requesting, each gives up after 3 cycles: strict rotation
        reset_pulse();
        got_q.delete();
        to_cnt = 0;
        polite(40, 3);
        for (int i = 0; i < 8; i++) check_order("t2_order", i, i % 7);
        check("t2_no_timeout", 32'(to_cnt), 0);
        req = 7'd0;
        repeat (3) step();

        // Wrap-around from ptr=6
        reset_pulse();
        en = 1'b1; req = 7'b0100000;
        got_q.delete();
        run_grants(1, 10);
        check_order("t3_first", 0, 5);
        req = 7'd0;
        repeat (3) step();
        req = 7'b1000001;
        got_q.delete();
        run_grants(3, 60);
        check_order("t3_wrap0", 0, 6);
        check_order("t3_wrap1", 1, 0);
        check_order("t3_wrap2", 2, 6);
        req = 7'd0;
        repeat (3) step();

        // Early drop by requester 3; ptr moves to 4
        req = 7'b0001000;
        got_q.delete();
        run_grants(1, 10);
        step();
        req = 7'd0;
        step();
        check("t4_gnt_drop", 32'(gnt), 0);
        check("t4_no_timeout", 32'(timeout), 0);
        check("t4_state_gap", 32'(dbg_state), ST_GAP);
        step();
        check("t4_state_idle", 32'(dbg_state), ST_IDLE);
        req = 7'h7F;
        got_q.delete();
        run_grants(1, 10);
        check_order("t4_next_ptr", 0, 4);
        req = 7'd0;
        repeat (3) step();

        // en gates new grants only
        reset_pulse();
        en = 1'b0; req = 7'h7F;
        got_q.delete();
        repeat (6) step();
        check("t5_no_grant", 32'(got_q.size()), 0);
        en = 1'b1;
        step();
        en = 1'b0;
        check("t5_gnt0", 32'(gnt), 32'h01);
        check("t5_sel0", 32'(sel), 0);
        repeat (20) step();
        check("t5_single_grant", 32'(got_q.size()), 1);
        check("t5_idle_after", 32'(gnt_valid), 0);
        req = 7'd0;
        repeat (2) step();

        // Reset mid-grant
        reset_pulse();
        en = 1'b1; req = 7'b0100000;
        got_q.delete();
        run_grants(1, 10);
        repeat (2) step();
        rst = 1'b1;
        step();
        check("t6_rst_gnt", 32'(gnt), 0);
        check("t6_rst_sel", 32'(sel), 0);
        check("t6_rst_valid", 32'(gnt_valid), 0);
        rst = 1'b0;
        step();
        check("t6_regrant", 32'(gnt), 32'h20);
        check("t6_regrant_sel", 32'(sel), 5);
        req = 7'd0;
        repeat (3) step();

        // Random traffic, checked cycle by cycle by the monitor
        reset_pulse();
        repeat (800) begin
            if ($urandom_range(0, 5) == 0) req = 7'($urandom_range(0, 127));
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; en = 1'b0; req = 7'd0;
        repeat (12) step();
        check("drain_grants", 32'(exp_gnt_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
